debug_access_bridge: RTL and testbench

DEBUG_ACCESS_BRIDGE -- requirements
Module: debug_access_bridge

---
 rtl/debug_access_bridge.sv | 173 +++++++++++++++++
 tb/tb_debug_access_bridge.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/debug_access_bridge.sv
// debug_access_bridge
//   Bridges single debug-controller accesses onto the instruction memory,
//   data memory and register-file read ports of a halted core.
//
//   State | Meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a rising edge on tx_flag
//   ACCESS| address driven; write enable pulsed for writes
//   WAIT  | read in flight, READ_LAT cycles, rdata captured on last one
//   DONE  | one-cycle done pulse (err set if the access was rejected)
//
//   Ports
//     CLK, RST                      clock, synchronous active-high reset
//     mode[2:0], tx_flag, halted    request from the debug controller
//     address_bridged, data_bridged access address and write data
//     data_internal                 last successful read result
//     busy, done, err               transaction status
//     imem_* / dmem_*               instruction / data memory ports
//     rf_addr, rf_rdata             register-file read port
module debug_access_bridge #(
    parameter int READ_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  mode,
    input  logic        tx_flag,
    input  logic        halted,
    input  logic [31:0] address_bridged,
    input  logic [31:0] data_bridged,
    output logic [31:0] data_internal,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        imem_we,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        dmem_we,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  rf_addr,
    input  logic [31:0] rf_rdata
);

    localparam logic [2:0] M_IMEM_RD = 3'b001;
    localparam logic [2:0] M_DMEM_RD = 3'b010;
    localparam logic [2:0] M_IMEM_WR = 3'b011;
    localparam logic [2:0] M_DMEM_WR = 3'b100;
    localparam logic [2:0] M_RF_RD   = 3'b101;

    localparam logic [2:0] WAIT_LOAD = 3'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic        tx_q;
    logic        armed;      // set once tx_flag has been seen low since reset
    logic [2:0]  mode_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        rej_q;
    logic [2:0]  cnt_q;

    logic        start;
    logic        is_mem;
    logic        is_rf;
    logic        reject;
    logic        is_write;
    logic        last_wait;
    logic        drive;
    logic [31:0] cap_val;

    assign start = tx_flag && !tx_q && armed && (state == IDLE);

    assign is_mem = (mode == M_IMEM_RD) || (mode == M_DMEM_RD) ||
                    (mode == M_IMEM_WR) || (mode == M_DMEM_WR);
    assign is_rf  = (mode == M_RF_RD);
    assign reject = !halted || !(is_mem || is_rf) ||
                    (is_mem && (address_bridged[1:0] != 2'b00)) ||
                    (is_rf && (address_bridged[31:5] != 27'd0));

    assign is_write  = (mode_q == M_IMEM_WR) || (mode_q == M_DMEM_WR);
    assign last_wait = (state == WAIT) && (cnt_q == 3'd0);
    assign drive     = (state == ACCESS) || (state == WAIT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            tx_q          <= 1'b0;
            armed         <= 1'b0;
            mode_q        <= 3'd0;
            addr_q        <= 32'd0;
            data_q        <= 32'd0;
            rej_q         <= 1'b0;
            cnt_q         <= 3'd0;
            data_internal <= 32'd0;
        end else begin
            state <= state_nxt;
            tx_q  <= tx_flag;
            armed <= armed || !tx_flag;
            if (start) begin
                mode_q <= mode;
                addr_q <= address_bridged;
                data_q <= data_bridged;
                rej_q  <= reject;
            end
            if (state == ACCESS) begin
                cnt_q <= WAIT_LOAD;
            end else if ((state == WAIT) && (cnt_q != 3'd0)) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (last_wait) begin
                data_internal <= cap_val;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = reject ? DONE : ACCESS;
            ACCESS:  state_nxt = is_write ? DONE : WAIT;
            WAIT:    if (cnt_q == 3'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cap_val = data_internal;
        case (mode_q)
            M_IMEM_RD: cap_val = imem_rdata;
            M_DMEM_RD: cap_val = dmem_rdata;
            // x0 is hardwired to zero whatever the register file returns
            M_RF_RD:   cap_val = (addr_q[4:0] == 5'd0) ? 32'd0 : rf_rdata;
            default:   cap_val = data_internal;
        endcase
    end

    always_comb begin
        imem_addr  = 32'd0;
        imem_wdata = 32'd0;
        imem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        dmem_we    = 1'b0;
        rf_addr    = 5'd0;
        if (drive) begin
            case (mode_q)
                M_IMEM_RD: imem_addr = addr_q;
                M_DMEM_RD: dmem_addr = addr_q;
                M_IMEM_WR: begin
                    imem_addr  = addr_q;
                    imem_wdata = data_q;
                    imem_we    = (state == ACCESS);
                end
                M_DMEM_WR: begin
                    dmem_addr  = addr_q;
                    dmem_wdata = data_q;
                    dmem_we    = (state == ACCESS);
                end
                M_RF_RD:   rf_addr = addr_q[4:0];
                default:   ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign err  = (state == DONE) && rej_q;

endmodule

// File: tb/tb_debug_access_bridge.sv
module tb_debug_access_bridge;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  mode;
    logic        tx_flag;
    logic        halted;
    logic [31:0] address_bridged;
    logic [31:0] data_bridged;
    logic [31:0] data_internal;
    logic        busy, done, err;
    logic [31:0] imem_addr, imem_wdata, imem_rdata;
    logic        imem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_rdata;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt;
    int we_cnt;

    debug_access_bridge #(.READ_LAT(1)) dut (
        .CLK(CLK), .RST(RST), .mode(mode), .tx_flag(tx_flag), .halted(halted),
        .address_bridged(address_bridged), .data_bridged(data_bridged),
        .data_internal(data_internal), .busy(busy), .done(done), .err(err),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_we(imem_we),
        .imem_rdata(imem_rdata), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_we(dmem_we), .dmem_rdata(dmem_rdata), .rf_addr(rf_addr),
        .rf_rdata(rf_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1; mode = 3'd0; tx_flag = 1'b1; halted = 1'b1;
        address_bridged = 32'd0; data_bridged = 32'd0;
        imem_rdata = 32'd0; dmem_rdata = 32'd0; rf_rdata = 32'd0;

        // reset, with tx_flag already high
        mode = 3'b100; address_bridged = 32'h40; data_bridged = 32'h1;
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data", data_internal, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        RST = 1'b0;
        we_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            we_cnt += int'(dmem_we) + int'(imem_we);
            done_cnt += int'(busy);
        end
        chk("post_rst_level_no_start", done_cnt, 32'd0);
        chk("post_rst_level_no_we", we_cnt, 32'd0);
        tx_flag = 1'b0; tick();

        // dmem write; inputs scrambled after the start edge
        halted = 1'b1; mode = 3'b100; address_bridged = 32'h40; data_bridged = 32'hDEADBEEF;
        tx_flag = 1'b1; tick();                           // now T1
        address_bridged = 32'h0000_FF00; data_bridged = 32'h0; mode = 3'b001;
        chk("wr_t1_dmem_we", {31'd0, dmem_we}, 32'd1);
        chk("wr_t1_imem_we", {31'd0, imem_we}, 32'd0);
        chk("wr_t1_addr", dmem_addr, 32'h40);
        chk("wr_t1_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("wr_t1_done", {31'd0, done}, 32'd0);
        tick();                                           // T2
        chk("wr_t2_done", {31'd0, done}, 32'd1);
        chk("wr_t2_err", {31'd0, err}, 32'd0);
        chk("wr_t2_we", {31'd0, dmem_we}, 32'd0);
        chk("wr_t2_data", data_internal, 32'd0);
        tx_flag = 1'b0; tick();
        chk("wr_idle_busy", {31'd0, busy}, 32'd0);
        chk("wr_idle_addr", dmem_addr, 32'd0);

        // imem read
        mode = 3'b001; address_bridged = 32'h10; imem_rdata = 32'h13;
        tx_flag = 1'b1; tick();                           // T1
        chk("rd_t1_addr", imem_addr, 32'h10);
        chk("rd_t1_we", {30'd0, imem_we, dmem_we}, 32'd0);
        chk("rd_t1_busy", {31'd0, busy}, 32'd1);
        tick();                                           // T2 (WAIT)
        chk("rd_t2_done", {31'd0, done}, 32'd0);
        chk("rd_t2_addr", imem_addr, 32'h10);
        chk("rd_t2_we", {30'd0, imem_we, dmem_we}, 32'd0);
        tick();                                           // T3
        chk("rd_t3_done", {31'd0, done}, 32'd1);
        chk("rd_t3_err", {31'd0, err}, 32'd0);
        chk("rd_t3_data", data_internal, 32'h13);
        tx_flag = 1'b0; tick();

        // rf read of x0 and x5
        mode = 3'b101; address_bridged = 32'd0; rf_rdata = 32'hFFFFFFFF;
        tx_flag = 1'b1; tick();
        chk("rf0_t1_addr", {27'd0, rf_addr}, 32'd0);
        tick(); tick();
        chk("rf0_t3_done", {31'd0, done}, 32'd1);
        chk("rf0_t3_data", data_internal, 32'd0);
        tx_flag = 1'b0; tick();
        address_bridged = 32'd5; rf_rdata = 32'h1234;
        tx_flag = 1'b1; tick();
        chk("rf5_t1_addr", {27'd0, rf_addr}, 32'd5);
        tick(); tick();
        chk("rf5_t3_done", {31'd0, done}, 32'd1);
        chk("rf5_t3_data", data_internal, 32'h1234);
        tx_flag = 1'b0; tick();

        // rejections: not halted, invalid mode, misaligned dmem write
        halted = 1'b0; mode = 3'b010; address_bridged = 32'h0;
        tx_flag = 1'b1; tick();
        chk("rej_halt_done", {31'd0, done}, 32'd1);
        chk("rej_halt_err", {31'd0, err}, 32'd1);
        chk("rej_halt_addr", dmem_addr, 32'd0);
        tick();
        chk("rej_halt_idle", {30'd0, busy, done}, 32'd0);
        tx_flag = 1'b0; tick();
        halted = 1'b1; mode = 3'b111;
        tx_flag = 1'b1; tick();
        chk("rej_mode_done_err", {30'd0, done, err}, 32'd3);
        chk("rej_mode_we", {30'd0, imem_we, dmem_we}, 32'd0);
        tx_flag = 1'b0; tick();
        mode = 3'b100; address_bridged = 32'h42; data_bridged = 32'h5555;
        tx_flag = 1'b1; tick();
        chk("rej_align_done_err", {30'd0, done, err}, 32'd3);
        chk("rej_align_we", {30'd0, imem_we, dmem_we}, 32'd0);
        chk("rej_align_data", data_internal, 32'h1234);
        tx_flag = 1'b0; tick();

        // level held high for 10 cycles starts a single write
        mode = 3'b100; address_bridged = 32'h80; data_bridged = 32'h1;
        tx_flag = 1'b1; done_cnt = 0; we_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            done_cnt += int'(done);
            we_cnt += int'(dmem_we);
        end
        chk("hold_one_done", done_cnt, 32'd1);
        chk("hold_one_we", we_cnt, 32'd1);
        tx_flag = 1'b0; tick();

        // second rising edge while busy is dropped
        mode = 3'b010; address_bridged = 32'h20; dmem_rdata = 32'hCAFE;
        tx_flag = 1'b1; done_cnt = 0;
        tick();                                           // T1
        tx_flag = 1'b0; tick();                           // T2
        tx_flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            done_cnt += int'(done);
        end
        chk("busy_edge_one_done", done_cnt, 32'd1);
        chk("busy_edge_idle", {31'd0, busy}, 32'd0);
        chk("busy_edge_data", data_internal, 32'hCAFE);
        tx_flag = 1'b0; tick();

        // reset in ACCESS of a write
        mode = 3'b100; address_bridged = 32'h40; data_bridged = 32'h77;
        tx_flag = 1'b1; tick();                           // T1
        chk("rstw_t1_we", {31'd0, dmem_we}, 32'd1);
        RST = 1'b1; tick();
        chk("rstw_we", {31'd0, dmem_we}, 32'd0);
        chk("rstw_busy", {31'd0, busy}, 32'd0);
        chk("rstw_data", data_internal, 32'd0);
        RST = 1'b0; tx_flag = 1'b0; done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            done_cnt += int'(done);
        end
        chk("rstw_no_done", done_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
